// File: rtl/dnn_pkg.sv
// Shared types and width helpers for the sequential MLP engine.
// Widths are chosen so no accumulation can overflow.
package dnn_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      L1   = 2'd1,
      L2   = 2'd2,
      DONE = 2'd3
   } state_e;

   function automatic int hid_w(int dw, int n_in);
      return 2 * dw + $clog2(n_in);
   endfunction

   function automatic int out_w(int dw, int hw, int n_hid);
      return hw + dw + $clog2(n_hid);
   endfunction

   function automatic int idx_w(int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dnn_mac.sv
// Signed multiply-accumulate with synchronous clear.
// Exposes the next accumulator value so callers can capture it.
module dnn_mac #(
   parameter int AW   = 12,
   parameter int BW   = 5,
   parameter int ACCW = 19
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en_i,
   input  logic                   clr_i,
   input  logic signed [AW-1:0]   a_i,
   input  logic signed [BW-1:0]   b_i,
   output logic signed [ACCW-1:0] acc_nxt_o
);

   logic signed [AW+BW-1:0] prod;
   logic signed [ACCW-1:0]  acc_q;
   logic signed [ACCW-1:0]  acc_d;

   // Full-precision product, restarted from zero when clr_i is set.
   always_comb begin
      prod  = a_i * b_i;
      acc_d = (clr_i ? '0 : acc_q) + ACCW'(prod);
   end

   // Accumulator register, only advances on an active MAC cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else if (en_i) begin
         acc_q <= acc_d;
      end
   end

   assign acc_nxt_o = acc_d;

endmodule

// File: rtl/dnn_seq_mlp.sv
// Time-multiplexed two-layer MLP: one shared MAC walks
// input->hidden then hidden->output weights, one product per cycle.
module dnn_seq_mlp
   import dnn_pkg::*;
#(
   parameter int DW       = 5,
   parameter int N_IN     = 4,
   parameter int N_HID    = 4,
   parameter int N_OUT    = 2,
   parameter int HID_RELU = 1
)(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [N_IN*DW-1:0]        x_in,
   input  logic [N_IN*N_HID*DW-1:0]  w_ih,
   input  logic [N_HID*N_OUT*DW-1:0] w_ho,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [N_OUT*out_w(DW, hid_w(DW, N_IN), N_HID)-1:0] y_out,
   output logic                      busy
);

   localparam int HW  = hid_w(DW, N_IN);
   localparam int OW  = out_w(DW, HW, N_HID);
   localparam int LAT = N_IN * N_HID + N_HID * N_OUT;
   localparam int IW  = idx_w(N_IN);
   localparam int JW  = idx_w(N_HID);
   localparam int KW  = idx_w(N_OUT);

   state_e state_q, state_d;
   logic [IW-1:0] i_q, i_d;
   logic [JW-1:0] j_q, j_d;
   logic [KW-1:0] k_q, k_d;

   logic [N_IN*DW-1:0]    x_q;
   logic signed [HW-1:0]  hid_q [N_HID];
   logic signed [OW-1:0]  y_q   [N_OUT];

   logic signed [DW-1:0]  xa  [N_IN];
   logic signed [DW-1:0]  wih [N_HID][N_IN];
   logic signed [DW-1:0]  who [N_OUT][N_HID];

   logic                  mac_en;
   logic                  mac_clr;
   logic signed [HW-1:0]  mac_a;
   logic signed [DW-1:0]  mac_b;
   logic signed [OW-1:0]  acc_d;

   logic                  last_i, last_j, last_k;
   logic                  accept;
   logic                  hid_we, y_we;
   logic signed [HW-1:0]  hsum, hid_d;

   for (genvar gi = 0; gi < N_IN; gi++) begin : g_x
      assign xa[gi] = x_q[gi*DW +: DW];
   end

   for (genvar gj = 0; gj < N_HID; gj++) begin : g_wj
      for (genvar gi = 0; gi < N_IN; gi++) begin : g_wi
         assign wih[gj][gi] = w_ih[(gj*N_IN+gi)*DW +: DW];
      end
   end

   for (genvar gk = 0; gk < N_OUT; gk++) begin : g_wk
      for (genvar gj = 0; gj < N_HID; gj++) begin : g_wj2
         assign who[gk][gj] = w_ho[(gk*N_HID+gj)*DW +: DW];
      end
      assign y_out[gk*OW +: OW] = y_q[gk];
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign accept    = in_valid && in_ready;

   assign last_i = (i_q == IW'(N_IN - 1));
   assign last_j = (j_q == JW'(N_HID - 1));
   assign last_k = (k_q == KW'(N_OUT - 1));

   // Route the shared MAC operands for the active layer.
   always_comb begin
      mac_en  = 1'b0;
      mac_clr = 1'b0;
      mac_a   = '0;
      mac_b   = '0;
      unique case (state_q)
         L1: begin
            mac_en  = 1'b1;
            mac_clr = (i_q == '0);
            mac_a   = HW'(xa[i_q]);
            mac_b   = wih[j_q][i_q];
         end
         L2: begin
            mac_en  = 1'b1;
            mac_clr = (j_q == '0);
            mac_a   = hid_q[j_q];
            mac_b   = who[k_q][j_q];
         end
         default: ;
      endcase
   end

   dnn_mac #(
      .AW   (HW),
      .BW   (DW),
      .ACCW (OW)
   ) u_mac (
      .clk       (clk),
      .rst_n     (rst_n),
      .en_i      (mac_en),
      .clr_i     (mac_clr),
      .a_i       (mac_a),
      .b_i       (mac_b),
      .acc_nxt_o (acc_d)
   );

   // Sequence L1 (j outer, i inner) then L2 (k outer, j inner).
   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      k_d     = k_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = L1;
               i_d     = '0;
               j_d     = '0;
               k_d     = '0;
            end
         end
         L1: begin
            if (last_i) begin
               i_d = '0;
               if (last_j) begin
                  j_d     = '0;
                  k_d     = '0;
                  state_d = L2;
               end else begin
                  j_d = j_q + JW'(1);
               end
            end else begin
               i_d = i_q + IW'(1);
            end
         end
         L2: begin
            if (last_j) begin
               j_d = '0;
               if (last_k) begin
                  k_d     = '0;
                  state_d = DONE;
               end else begin
                  k_d = k_q + KW'(1);
               end
            end else begin
               j_d = j_q + JW'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM state and loop counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         i_q     <= '0;
         j_q     <= '0;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         k_q     <= k_d;
      end
   end

   // Capture the input vector on the accept edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q <= '0;
      end else if (accept) begin
         x_q <= x_in;
      end
   end

   assign hid_we = (state_q == L1) && last_i;
   assign y_we   = (state_q == L2) && last_j;
   assign hsum   = acc_d[HW-1:0];
   assign hid_d  = ((HID_RELU != 0) && hsum[HW-1]) ? '0 : hsum;

   // Hidden activations, written when a neuron's last product lands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int n = 0; n < N_HID; n++) hid_q[n] <= '0;
      end else if (hid_we) begin
         hid_q[j_q] <= hid_d;
      end
   end

   // Output lanes, each updated only when its own sum completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int n = 0; n < N_OUT; n++) y_q[n] <= '0;
      end else if (y_we) begin
         y_q[k_q] <= acc_d;
      end
   end

endmodule

// File: tb/tb_dnn_seq_mlp.sv
// Randomised and directed checks of dnn_seq_mlp against an
// integer reference model; ReLU and linear variants run side by side.
module tb_dnn_seq_mlp;

   localparam int DW    = 5;
   localparam int N_IN  = 4;
   localparam int N_HID = 4;
   localparam int N_OUT = 2;
   localparam int OW    = 19;
   localparam int LAT   = 24;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0;
   logic out_ready = 1'b0;
   logic [N_IN*DW-1:0] x_in = '0;
   logic [N_IN*N_HID*DW-1:0] w_ih = '0;
   logic [N_HID*N_OUT*DW-1:0] w_ho = '0;

   logic in_ready, out_valid, busy;
   logic [N_OUT*OW-1:0] y_out;
   logic in_ready_l, out_valid_l, busy_l;
   logic [N_OUT*OW-1:0] y_out_l;

   int checks = 0;
   int errors = 0;

   int tx   [N_IN];
   int twih [N_HID][N_IN];
   int twho [N_OUT][N_HID];

   always #5 clk = ~clk;

   dnn_seq_mlp #(.DW(DW), .N_IN(N_IN), .N_HID(N_HID),
                 .N_OUT(N_OUT), .HID_RELU(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .in_ready(in_ready), .x_in(x_in), .w_ih(w_ih),
      .w_ho(w_ho), .out_valid(out_valid),
      .out_ready(out_ready), .y_out(y_out), .busy(busy)
   );

   dnn_seq_mlp #(.DW(DW), .N_IN(N_IN), .N_HID(N_HID),
                 .N_OUT(N_OUT), .HID_RELU(0)) dut_lin (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .in_ready(in_ready_l), .x_in(x_in), .w_ih(w_ih),
      .w_ho(w_ho), .out_valid(out_valid_l),
      .out_ready(out_ready), .y_out(y_out_l), .busy(busy_l)
   );

   // Reference: plain integer network evaluation.
   function automatic int model_y(int k, bit relu);
      int h, acc;
      acc = 0;
      for (int j = 0; j < N_HID; j++) begin
         h = 0;
         for (int i = 0; i < N_IN; i++) h += tx[i] * twih[j][i];
         if (relu && h < 0) h = 0;
         acc += h * twho[k][j];
      end
      return acc;
   endfunction

   function automatic int rnd5();
      return int'($urandom_range(31)) - 16;
   endfunction

   task automatic apply_vectors();
      for (int i = 0; i < N_IN; i++)
         x_in[i*DW +: DW] = DW'(tx[i]);
      for (int j = 0; j < N_HID; j++)
         for (int i = 0; i < N_IN; i++)
            w_ih[(j*N_IN+i)*DW +: DW] = DW'(twih[j][i]);
      for (int k = 0; k < N_OUT; k++)
         for (int j = 0; j < N_HID; j++)
            w_ho[(k*N_HID+j)*DW +: DW] = DW'(twho[k][j]);
   endtask

   task automatic fill_seq_x();
      for (int i = 0; i < N_IN; i++) tx[i] = i + 1;
   endtask

   task automatic fill_w(int a, int b);
      for (int j = 0; j < N_HID; j++)
         for (int i = 0; i < N_IN; i++) twih[j][i] = a;
      for (int k = 0; k < N_OUT; k++)
         for (int j = 0; j < N_HID; j++) twho[k][j] = b;
   endtask

   task automatic fill_random();
      for (int i = 0; i < N_IN; i++) tx[i] = rnd5();
      for (int j = 0; j < N_HID; j++)
         for (int i = 0; i < N_IN; i++) twih[j][i] = rnd5();
      for (int k = 0; k < N_OUT; k++)
         for (int j = 0; j < N_HID; j++) twho[k][j] = rnd5();
   endtask

   // Accept one job and count edges until out_valid (bounded).
   task automatic run_job(output int lat);
      @(negedge clk);
      apply_vectors();
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic release_job();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
         errors++;
         $display("FAIL reset_hs got %b want 100",
                  {in_ready, out_valid, busy});
      end
      checks++;
      if (y_out !== '0 || y_out_l !== '0) begin
         errors++;
         $display("FAIL reset_y got %h/%h want 0", y_out, y_out_l);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL post_reset rdy %b busy %b want 1 0",
                  in_ready, busy);
      end
   endtask

   task automatic test_basic();
      int lat;
      logic signed [OW-1:0] yv;
      fill_seq_x();
      fill_w(1, 1);
      run_job(lat);
      checks++;
      if (lat !== LAT) begin
         errors++;
         $display("FAIL basic_lat got %0d want %0d", lat, LAT);
      end
      checks++;
      if ({in_ready, busy, out_valid_l} !== 3'b011) begin
         errors++;
         $display("FAIL basic_flags got %b want 011",
                  {in_ready, busy, out_valid_l});
      end
      for (int k = 0; k < N_OUT; k++) begin
         yv = y_out[k*OW +: OW];
         checks++;
         if (yv !== OW'(40)) begin
            errors++;
            $display("FAIL basic_y%0d got %0d want 40", k, yv);
         end
      end
      release_job();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL basic_hs ov %b rdy %b want 0 1",
                  out_valid, in_ready);
      end
   endtask

   task automatic test_relu();
      int lat;
      logic signed [OW-1:0] yv, yl;
      fill_seq_x();
      fill_w(-1, 1);
      run_job(lat);
      for (int k = 0; k < N_OUT; k++) begin
         yv = y_out[k*OW +: OW];
         yl = y_out_l[k*OW +: OW];
         checks++;
         if (yv !== OW'(0)) begin
            errors++;
            $display("FAIL relu_y%0d got %0d want 0", k, yv);
         end
         checks++;
         if (yl !== OW'(-40)) begin
            errors++;
            $display("FAIL lin_y%0d got %0d want -40", k, yl);
         end
      end
      release_job();
   endtask

   task automatic test_extreme();
      int lat;
      logic signed [OW-1:0] yv, yl;
      for (int i = 0; i < N_IN; i++) tx[i] = -16;
      fill_w(-16, -16);
      run_job(lat);
      for (int k = 0; k < N_OUT; k++) begin
         yv = y_out[k*OW +: OW];
         yl = y_out_l[k*OW +: OW];
         checks++;
         if (yv !== OW'(-65536) || yl !== OW'(-65536)) begin
            errors++;
            $display("FAIL extreme_y%0d got %0d/%0d want -65536",
                     k, yv, yl);
         end
      end
      release_job();
   endtask

   task automatic test_random();
      int lat;
      logic signed [OW-1:0] yv, yl;
      for (int n = 0; n < 6; n++) begin
         fill_random();
         run_job(lat);
         checks++;
         if (lat !== LAT) begin
            errors++;
            $display("FAIL rand%0d_lat got %0d want %0d",
                     n, lat, LAT);
         end
         for (int k = 0; k < N_OUT; k++) begin
            yv = y_out[k*OW +: OW];
            yl = y_out_l[k*OW +: OW];
            checks++;
            if (yv !== OW'(model_y(k, 1'b1))) begin
               errors++;
               $display("FAIL rand%0d_y%0d got %0d want %0d",
                        n, k, yv, model_y(k, 1'b1));
            end
            checks++;
            if (yl !== OW'(model_y(k, 1'b0))) begin
               errors++;
               $display("FAIL rand%0d_lin%0d got %0d want %0d",
                        n, k, yl, model_y(k, 1'b0));
            end
         end
         release_job();
      end
   endtask

   task automatic test_backpressure();
      int lat;
      logic [N_OUT*OW-1:0] hold;
      logic [N_OUT*OW-1:0] want;
      fill_random();
      run_job(lat);
      for (int k = 0; k < N_OUT; k++)
         want[k*OW +: OW] = OW'(model_y(k, 1'b1));
      hold = y_out;
      checks++;
      if (hold !== want) begin
         errors++;
         $display("FAIL bp_y got %h want %h", hold, want);
      end
      for (int c = 0; c < 10; c++) begin
         in_valid = c[0];
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
             y_out !== want) begin
            errors++;
            $display("FAIL bp_hold%0d ov %b rdy %b y %h want 1 0 %h",
                     c, out_valid, in_ready, y_out, want);
         end
      end
      in_valid = 1'b0;
      release_job();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
          busy !== 1'b0 || y_out !== want) begin
         errors++;
         $display("FAIL bp_release ov %b rdy %b busy %b y %h",
                  out_valid, in_ready, busy, y_out);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL bp_no_queue busy %b want 0", busy);
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      logic signed [OW-1:0] yv;
      fill_random();
      @(negedge clk);
      apply_vectors();
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (6) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
          busy !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_hs ov %b rdy %b busy %b want 0 1 0",
                  out_valid, in_ready, busy);
      end
      checks++;
      if (y_out !== '0 || y_out_l !== '0) begin
         errors++;
         $display("FAIL rstmid_y got %h/%h want 0", y_out, y_out_l);
      end
      @(negedge clk);
      rst_n = 1'b1;
      fill_seq_x();
      fill_w(1, 1);
      run_job(lat);
      checks++;
      if (lat !== LAT) begin
         errors++;
         $display("FAIL rstmid_lat got %0d want %0d", lat, LAT);
      end
      for (int k = 0; k < N_OUT; k++) begin
         yv = y_out[k*OW +: OW];
         checks++;
         if (yv !== OW'(40)) begin
            errors++;
            $display("FAIL rstmid_y%0d got %0d want 40", k, yv);
         end
      end
      release_job();
   endtask

   task automatic test_back_to_back();
      int xs [3][N_IN];
      int ex [3][N_OUT];
      int acc_t [3];
      int na, nr, cyc;
      logic signed [OW-1:0] yv;
      fill_random();
      for (int n = 0; n < 3; n++) begin
         for (int i = 0; i < N_IN; i++) begin
            xs[n][i] = rnd5();
            tx[i] = xs[n][i];
         end
         xs[n][0] = n - 8;
         tx[0] = xs[n][0];
         for (int k = 0; k < N_OUT; k++) ex[n][k] = model_y(k, 1'b1);
      end
      na = 0;
      nr = 0;
      cyc = 0;
      out_ready = 1'b1;
      @(negedge clk);
      while (nr < 3 && cyc < 300) begin
         if (out_valid === 1'b1) begin
            for (int k = 0; k < N_OUT; k++) begin
               yv = y_out[k*OW +: OW];
               checks++;
               if (yv !== OW'(ex[nr][k])) begin
                  errors++;
                  $display("FAIL b2b%0d_y%0d got %0d want %0d",
                           nr, k, yv, ex[nr][k]);
               end
            end
            nr++;
         end
         if (in_ready === 1'b1) begin
            if (na < 3) begin
               for (int i = 0; i < N_IN; i++) tx[i] = xs[na][i];
               apply_vectors();
               in_valid = 1'b1;
               acc_t[na] = cyc;
               na++;
            end else begin
               in_valid = 1'b0;
            end
         end else if (na == 3) begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      checks++;
      if (nr !== 3 || na !== 3) begin
         errors++;
         $display("FAIL b2b_count results %0d accepts %0d want 3 3",
                  nr, na);
      end
      for (int n = 1; n < na; n++) begin
         checks++;
         if (acc_t[n] - acc_t[n-1] !== LAT + 2) begin
            errors++;
            $display("FAIL b2b_gap%0d got %0d want %0d",
                     n, acc_t[n] - acc_t[n-1], LAT + 2);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_relu();
      test_extreme();
      test_random();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
